hbridge_pwm_gen: RTL
====================

HBRIDGE_PWM_GEN -- requirements
Module: hbridge_pwm_gen

Interface
REQ-001 Parameter CNT_W, default 8: period counter width; the period is 2^CNT_W clocks.
REQ-002 Parameter MIN_PULSE, default 16: the shortest high or low phase emitted. It exceeds the downstream 13-clock dead-time window.
REQ-003 Port GCK1, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 Port GSR1, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port enable, input, 1 bit: run request, level-sensitive.
REQ-006 Port fault_n, input, 1 bit: active-low hardware fault, asynchronous to GCK1.
REQ-007 Port duty_valid, input, 1 bit: a new duty word is offered.
REQ-008 Port duty, input, CNT_W bits: requested high time in clocks per period.
REQ-009 Port duty_ready, output, 1 bit: the shadow register can accept a word.
REQ-010 Port Hbridge_pwm, output, 1 bit: direction/PWM line to the H-bridge driver CPLD.
REQ-011 Port period_start, output, 1 bit: one-clock pulse on the first clock of each period while in RUN.
REQ-012 Port fault_latched, output, 1 bit: high while in FAULT.

Function
REQ-013 fault_n SHALL pass through a 2-flop synchronizer before use.
REQ-014 The state machine SHALL have three states:
- IDLE: counter held at 0; Hbridge_pwm = 0.
- RUN: counter increments each clock and wraps from 2^CNT_W-1 to 0.
- FAULT: Hbridge_pwm = 0; counter held at 0.
REQ-015 IDLE->RUN SHALL occur when enable=1 and the synchronized fault_n=1. The first RUN clock has counter=0 and asserts period_start.
REQ-016 RUN->IDLE SHALL occur on the clock after enable=0, with no waiting for the period end.
REQ-017 Any state SHALL go to FAULT when the synchronized fault_n=0. FAULT has priority over every other transition.
REQ-018 FAULT->IDLE SHALL occur only when the synchronized fault_n=1 and enable=0, which forces software to re-arm.
REQ-019 Handshake: a word is accepted on a clock with duty_valid & duty_ready. duty_ready = !shadow_full.
REQ-020 The shadow SHALL copy into active_duty on the last clock of a period (counter = 2^CNT_W-1) or on IDLE->RUN.
- shadow_full clears on that copy, so duty_ready rises the next clock.
- An acceptance on the same clock as the copy is impossible, because ready is low while full.
REQ-021 The active duty SHALL be clamped once, at the copy:
- d < MIN_PULSE gives 0 (constant low);
- d > 2^CNT_W - MIN_PULSE gives 2^CNT_W (constant high);
- otherwise d unchanged.
- active_duty is CNT_W+1 bits wide.
REQ-022 In RUN, Hbridge_pwm SHALL be registered as (counter < active_duty), giving one clock of latency from the counter.
REQ-023 A duty change SHALL never alter the current period, so every high and low phase is at least MIN_PULSE clocks.
REQ-024 Words accepted while in IDLE or FAULT SHALL stay in the shadow until the next copy.

Reset
REQ-025 On GSR1 low, the block SHALL immediately enter IDLE with these values: counter=0, active_duty=0, shadow=0, shadow_full=0, duty_ready=1, Hbridge_pwm=0, period_start=0, fault_latched=0, synchronizer flops=1.
REQ-026 Reset during RUN SHALL drive Hbridge_pwm low asynchronously.
REQ-027 After GSR1 release, the block SHALL reach RUN no earlier than the 2nd rising edge with enable=1.

Structure
REQ-028 The state encoding (IDLE/RUN/FAULT) and the defaults for CNT_W and MIN_PULSE SHALL live in the shared package hbridge_pkg.
REQ-029 The fault synchronizer SHALL be the sub-module sync2. There are no other sub-modules.

Verification
REQ-030 Directed scenarios (CNT_W=8, MIN_PULSE=16):
- duty=128 loaded, enable=1: Hbridge_pwm high 128 and low 128 clocks per period; period_start every 256 clocks.
- duty=8, then duty=250: output constant 0, then constant 1; no pulse shorter than 16 clocks.
- duty=64 accepted mid-period while running at 200: the current period keeps 200 high; the next period has 64; duty_ready low until the copy, high one clock later.
- fault_n low for 1 clock mid-high: Hbridge_pwm low within 3 clocks and fault_latched=1; stays in FAULT while enable=1; IDLE after enable=0.
- GSR1 pulsed low during a high phase: Hbridge_pwm low with no clock edge; duty_ready=1; counter=0.
- duty_valid held high continuously: exactly one word accepted per period.

Source files
------------

// File: rtl/hbridge_pkg.sv
// Shared definitions for the H-bridge PWM generator: controller states and
// the default counter width / minimum pulse length.
package hbridge_pkg;

    localparam int CNT_W_DEF     = 8;
    localparam int MIN_PULSE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } hbState_t;

endpackage

// File: rtl/hbridge_pwm_gen_sync2.sv
// Two-flop synchronizer for an asynchronous active-low level.
// It resets to the inactive (high) level.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hbridge_pwm_gen.sv
// H-bridge PWM generator: a free-running period counter, a shadowed and clamped
// duty word, and an IDLE/RUN/FAULT controller with a synchronized fault input.
module hbridge_pwm_gen
    import hbridge_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MIN_PULSE = MIN_PULSE_DEF
) (
    input  logic             GCK1,
    input  logic             GSR1,
    input  logic             enable,
    input  logic             fault_n,
    input  logic             duty_valid,
    input  logic [CNT_W-1:0] duty,
    output logic             duty_ready,
    output logic             Hbridge_pwm,
    output logic             period_start,
    output logic             fault_latched
);

    localparam logic [CNT_W:0]   FULL_DUTY = {1'b1, {CNT_W{1'b0}}};
    localparam logic [CNT_W:0]   MIN_P     = (CNT_W + 1)'(MIN_PULSE);
    localparam logic [CNT_W:0]   HIGH_LIM  = FULL_DUTY - MIN_P;
    localparam logic [CNT_W-1:0] CNT_LAST  = {CNT_W{1'b1}};

    hbState_t         state;
    hbState_t         nextState;
    logic             faultSync;
    logic             rstDone;
    logic             stayRun;
    logic             copyShadow;
    logic             accept;
    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] shadowDuty;
    logic             shadowFull;
    logic [CNT_W:0]   activeDuty;
    logic             pwm_p1;

    // Short requests become constant low and near-full requests constant high,
    // so no emitted phase is ever shorter than MIN_PULSE.
    function automatic logic [CNT_W:0] clampDuty(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] dExt;
        dExt = {1'b0, d};
        if (dExt < MIN_P) begin
            return '0;
        end else if (dExt > HIGH_LIM) begin
            return FULL_DUTY;
        end else begin
            return dExt;
        end
    endfunction

    sync2 uFaultSync (
        .clk   (GCK1),
        .rst_n (GSR1),
        .d     (fault_n),
        .q     (faultSync)
    );

    // rstDone keeps the first edge after reset release from starting a run.
    always_ff @(posedge GCK1 or negedge GSR1) begin
        if (!GSR1) begin
            state   <= IDLE;
            rstDone <= 1'b0;
        end else begin
            state   <= nextState;
            rstDone <= 1'b1;
        end
    end

    always_comb begin
        nextState     = state;
        period_start  = 1'b0;
        fault_latched = 1'b0;
        case (state)
            IDLE: begin
                if (enable && rstDone) nextState = RUN;
            end
            RUN: begin
                period_start = (cnt_p0 == '0);
                if (!enable) nextState = IDLE;
            end
            FAULT: begin
                fault_latched = 1'b1;
                if (!enable) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (!faultSync) nextState = FAULT;
    end

    assign stayRun    = (state == RUN) && (nextState == RUN);
    assign copyShadow = ((state == RUN) && (cnt_p0 == CNT_LAST)) ||
                        ((state == IDLE) && (nextState == RUN));
    assign duty_ready = !shadowFull;
    assign accept     = duty_valid && duty_ready;

    // Stage p0: period counter, zero outside RUN
    always_ff @(posedge GCK1 or negedge GSR1) begin
        if (!GSR1) begin
            cnt_p0 <= '0;
        end else if (stayRun) begin
            cnt_p0 <= cnt_p0 + 1'b1;
        end else begin
            cnt_p0 <= '0;
        end
    end

    // A word accepted on a copy edge waits for the following copy.
    always_ff @(posedge GCK1 or negedge GSR1) begin
        if (!GSR1) begin
            shadowDuty <= '0;
            shadowFull <= 1'b0;
            activeDuty <= '0;
        end else begin
            if (accept) shadowDuty <= duty;
            if (accept) begin
                shadowFull <= 1'b1;
            end else if (copyShadow) begin
                shadowFull <= 1'b0;
            end
            if (copyShadow) activeDuty <= clampDuty(shadowDuty);
        end
    end

    // Stage p1: registered compare; forced low on any exit from RUN
    always_ff @(posedge GCK1 or negedge GSR1) begin
        if (!GSR1) begin
            pwm_p1 <= 1'b0;
        end else begin
            pwm_p1 <= stayRun && ({1'b0, cnt_p0} < activeDuty);
        end
    end

    assign Hbridge_pwm = pwm_p1;

endmodule
